sram_bist_ctrl: RTL

Parametrised SRAM exerciser sitting between board I/O (debounced button ticks, switches) and the `sram_ctrl` memory controller. Provides manual single-word write/read and an automatic two-pass built-in self-test over a configurable address range, with error counting and first-failure capture. Drives the controller's `mem`/`rw`/`addr`/`data_f2s` request port and observes its `ready`/`data_s2f` return.

---
 rtl/sram_bist_pkg.sv | 30 +++
 rtl/sram_bist_if.sv | 17 +
 rtl/sram_bist_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and helpers for the SRAM exerciser: FSM states, op encoding,
// and the test pattern generator.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    M_ISSUE,
    M_WAIT,
    W_ISSUE,
    W_WAIT,
    R_ISSUE,
    R_WAIT,
    FIN
  } bist_state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  // Wide enough for any practical DW/AW; callers extend inputs and cast the result.
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] a,
                                               input logic [PAT_W-1:0] seed,
                                               input logic             p);
    logic [PAT_W-1:0] x;
    x = a ^ seed;
    return p ? ~x : x;
  endfunction

endpackage

// File: rtl/sram_bist_if.sv
// Request/return port between the exerciser (master) and the SRAM controller (slave).
// Handshake: mem is a one-cycle strobe issued only while ready=1; ready drops the
// cycle after an accepted strobe and its return high marks completion (read data valid).
interface sram_bist_if #(
  parameter int DW = 8,
  parameter int AW = 19
);
  logic          mem;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_f2s;
  logic          ready;
  logic [DW-1:0] data_s2f;

  modport master (output mem, rw, addr, data_f2s, input ready, data_s2f);
  modport slave  (input mem, rw, addr, data_f2s, output ready, data_s2f);
endinterface

// File: rtl/sram_bist_ctrl.sv
// SRAM exerciser: manual single-word write/read plus a two-pass write/read-verify
// self test over 0..LAST_ADDR with saturating error count and first-failure capture.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int          DW        = 8,
  parameter int          AW        = 19,
  parameter int unsigned LAST_ADDR = 2**AW-1,
  parameter int          CW        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_auto,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [AW-1:0]     man_addr,
  input  logic [DW-1:0]     man_data,
  input  logic [DW-1:0]     seed,
  sram_bist_if.master       bus,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     err_cnt,
  output logic [AW-1:0]     first_err_addr,
  output bist_state_t       fsm_state
);

  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

  bist_state_t   state, state_next;
  logic          op_rw;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_data;
  logic [AW-1:0] cnt_addr;
  logic [DW-1:0] seed_q;
  logic          pass_bit;

  logic          issue_fire;
  logic          wait_done;
  logic          at_last;
  logic          cur_rw;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic [DW-1:0] expected;

  assign at_last   = (cnt_addr == LAST);
  assign expected  = DW'(pattern(PAT_W'(cnt_addr), PAT_W'(seed_q), pass_bit));
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The strobe cycle itself still sees ready=1 from the controller, so a WAIT
  // only completes once our own strobe has dropped.
  always_comb begin
    state_next = state;
    issue_fire = 1'b0;
    wait_done  = 1'b0;
    cur_rw     = OP_READ;
    cur_addr   = cnt_addr;
    cur_data   = expected;
    case (state)
      IDLE: begin
        if (start_auto)           state_next = W_ISSUE;
        else if (wr_req || rd_req) state_next = M_ISSUE;
      end
      M_ISSUE: begin
        cur_rw   = op_rw;
        cur_addr = op_addr;
        cur_data = op_data;
        if (bus.ready) begin
          issue_fire = 1'b1;
          state_next = M_WAIT;
        end
      end
      W_ISSUE: begin
        cur_rw = OP_WRITE;
        if (bus.ready) begin
          issue_fire = 1'b1;
          state_next = W_WAIT;
        end
      end
      R_ISSUE: begin
        if (bus.ready) begin
          issue_fire = 1'b1;
          state_next = R_WAIT;
        end
      end
      M_WAIT: begin
        if (bus.ready && !bus.mem) begin
          wait_done  = 1'b1;
          state_next = IDLE;
        end
      end
      W_WAIT: begin
        if (bus.ready && !bus.mem) begin
          wait_done  = 1'b1;
          state_next = at_last ? R_ISSUE : W_ISSUE;
        end
      end
      R_WAIT: begin
        if (bus.ready && !bus.mem) begin
          wait_done = 1'b1;
          if (!at_last)     state_next = R_ISSUE;
          else if (pass_bit) state_next = FIN;
          else               state_next = W_ISSUE;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem        <= 1'b0;
      bus.rw         <= OP_READ;
      bus.addr       <= '0;
      bus.data_f2s   <= '0;
      rd_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      op_rw          <= OP_READ;
      op_addr        <= '0;
      op_data        <= '0;
      cnt_addr       <= '0;
      seed_q         <= '0;
      pass_bit       <= 1'b0;
    end else begin
      bus.mem      <= issue_fire;
      bus.rw       <= issue_fire ? cur_rw : OP_READ;
      bus.data_f2s <= (issue_fire && cur_rw == OP_WRITE) ? cur_data : '0;
      if (issue_fire) bus.addr <= cur_addr;
      busy <= (state_next != IDLE);
      done <= (state == FIN);
      if (state == FIN) pass <= (err_cnt == '0);

      case (state)
        IDLE: begin
          if (start_auto) begin
            seed_q         <= seed;
            pass_bit       <= 1'b0;
            cnt_addr       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
          end else if (wr_req || rd_req) begin
            op_rw   <= wr_req ? OP_WRITE : OP_READ;
            op_addr <= man_addr;
            op_data <= man_data;
          end
        end
        M_WAIT: begin
          if (wait_done && op_rw == OP_READ) rd_data <= bus.data_s2f;
        end
        W_WAIT: begin
          if (wait_done) cnt_addr <= at_last ? '0 : cnt_addr + 1'b1;
        end
        R_WAIT: begin
          if (wait_done) begin
            if (bus.data_s2f != expected) begin
              if (err_cnt != '1)  err_cnt <= err_cnt + 1'b1;
              if (err_cnt == '0)  first_err_addr <= cnt_addr;
            end
            cnt_addr <= at_last ? '0 : cnt_addr + 1'b1;
            if (at_last) pass_bit <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
